// File: rtl/uart_fir_bridge_if.sv
// Signal bundle between the UART/FIR bridge and its environment.
// The master modport is the bridge itself; slave is the UART core plus FIR side.
interface uart_fir_bridge_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 38
);
  logic [7:0]       rx_data;
  logic             rx_done;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             input_valid;
  logic [IN_W-1:0]  fir_data_in;
  logic             output_valid;
  logic [OUT_W-1:0] fir_data_out;
  logic             rx_timeout;
  logic             overflow;

  modport master (
    input  rx_data, rx_done, tx_busy, output_valid, fir_data_out,
    output tx_start, tx_data, input_valid, fir_data_in, rx_timeout, overflow
  );

  modport slave (
    output rx_data, rx_done, tx_busy, output_valid, fir_data_out,
    input  tx_start, tx_data, input_valid, fir_data_in, rx_timeout, overflow
  );
endinterface

// File: rtl/uart_fir_bridge.sv
// Byte-stream <-> sample bridge: packs UART bytes into FIR samples and serialises
// FIR results, buffered in a small FIFO, back out through the UART transmitter.
module uart_fir_bridge #(
  parameter int IN_W        = 16,
  parameter int OUT_W       = 38,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter bit MSB_FIRST   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  uart_fir_bridge_if.master bus
);
  localparam int IN_BYTES  = (IN_W + 32'sd7) / 32'sd8;
  localparam int OUT_BYTES = (OUT_W + 32'sd7) / 32'sd8;
  localparam int AS_W      = 32'sd8 * IN_BYTES;
  localparam int SH_W      = 32'sd8 * OUT_BYTES;
  localparam int IDX_W     = (IN_BYTES > 32'sd1) ? $clog2(IN_BYTES) : 32'sd1;
  localparam int TMO_W     = (TIMEOUT_CYC > 32'sd1) ? $clog2(TIMEOUT_CYC) : 32'sd1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 32'sd1;
  localparam int BC_W      = $clog2(OUT_BYTES + 32'sd1);
  localparam bit TMO_EN    = (TIMEOUT_CYC > 32'sd0);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_BYTES - 32'sd1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? (TIMEOUT_CYC - 32'sd1) : 32'sd0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(OUT_BYTES - 32'sd1);

  typedef enum logic [2:0] {
    T_IDLE    = 3'd0,
    T_LOAD    = 3'd1,
    T_SEND    = 3'd2,
    T_WAIT_HI = 3'd3,
    T_WAIT_LO = 3'd4
  } tx_state_e;

  logic [IDX_W-1:0]                 byte_idx_q, byte_idx_d;
  logic [AS_W-1:0]                  asm_q, asm_d;
  logic [IN_W-1:0]                  fir_data_in_q, fir_data_in_d;
  logic                             input_valid_q, input_valid_d;
  logic [TMO_W-1:0]                 tmo_q, tmo_d;
  logic                             rx_timeout_q, rx_timeout_d;
  logic [FIFO_DEPTH-1:0][OUT_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             overflow_q, overflow_d;
  tx_state_e                        state_q, state_d;
  logic [SH_W-1:0]                  sh_q, sh_d;
  logic [BC_W-1:0]                  byte_cnt_q, byte_cnt_d;
  logic                             tx_start_q, tx_start_d;
  logic [7:0]                       tx_data_q, tx_data_d;
  logic [IDX_W-1:0]                 slot_s;
  logic                             push_s, pop_s;

  // RX packing and partial-sample timeout
  always_comb begin
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    fir_data_in_d = fir_data_in_q;
    input_valid_d = 1'b0;
    tmo_d         = tmo_q;
    rx_timeout_d  = 1'b0;
    slot_s        = MSB_FIRST ? (IDX_LAST - byte_idx_q) : byte_idx_q;
    if (bus.rx_done) begin
      asm_d[{slot_s, 3'b000} +: 8] = bus.rx_data;
      tmo_d = '0;
      if (byte_idx_q == IDX_LAST) begin
        byte_idx_d    = '0;
        input_valid_d = 1'b1;
        fir_data_in_d = asm_d[IN_W-1:0];
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end else if (TMO_EN && (byte_idx_q != '0)) begin
      if (tmo_q == TMO_LAST) begin
        byte_idx_d   = '0;
        tmo_d        = '0;
        rx_timeout_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Result FIFO; when full, a same-cycle pop frees the slot being written
  always_comb begin
    pop_s      = (state_q == T_LOAD);
    push_s     = bus.output_valid && ((count_q != CNT_FULL) || pop_s);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = bus.fir_data_out;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else if (bus.output_valid) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // TX serialiser; the shift register moves the next byte into position on each send
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    byte_cnt_d = byte_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      T_IDLE: begin
        if (count_q != '0) begin
          state_d = T_LOAD;
        end else begin
          state_d = T_IDLE;
        end
      end
      T_LOAD: begin
        sh_d              = '0;
        sh_d[OUT_W-1:0]   = mem_q[rd_ptr_q];
        byte_cnt_d        = '0;
        state_d           = T_SEND;
      end
      T_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = MSB_FIRST ? sh_q[SH_W-1 -: 8] : sh_q[7:0];
          sh_d       = MSB_FIRST ? (sh_q << 4'd8) : (sh_q >> 4'd8);
          state_d    = T_WAIT_HI;
        end else begin
          state_d = T_SEND;
        end
      end
      T_WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = T_WAIT_LO;
        end else begin
          state_d = T_WAIT_HI;
        end
      end
      T_WAIT_LO: begin
        if (!bus.tx_busy) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = (byte_cnt_q == BC_LAST) ? T_IDLE : T_SEND;
        end else begin
          state_d = T_WAIT_LO;
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q    <= '0;
      asm_q         <= '0;
      fir_data_in_q <= '0;
      input_valid_q <= 1'b0;
      tmo_q         <= '0;
      rx_timeout_q  <= 1'b0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      state_q       <= T_IDLE;
      sh_q          <= '0;
      byte_cnt_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
    end else begin
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      fir_data_in_q <= fir_data_in_d;
      input_valid_q <= input_valid_d;
      tmo_q         <= tmo_d;
      rx_timeout_q  <= rx_timeout_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      sh_q          <= sh_d;
      byte_cnt_q    <= byte_cnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.input_valid = input_valid_q;
  assign bus.fir_data_in = fir_data_in_q;
  assign bus.rx_timeout  = rx_timeout_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_fir_bridge.sv
// Scoreboard bench for uart_fir_bridge: an LSB-first instance (short timeout) and an
// MSB-first instance share the RX stimulus; monitors compare outputs against queues.
`timescale 1ns/1ps
module tb_uart_fir_bridge;
  localparam int IN_W  = 16;
  localparam int OUT_W = 38;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fir_bridge_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  uart_fir_bridge_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_m ();

  uart_fir_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(4), .TIMEOUT_CYC(100),
                    .MSB_FIRST(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  uart_fir_bridge #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(4), .TIMEOUT_CYC(100),
                    .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.master));

  assign bus_m.rx_data      = bus.rx_data;
  assign bus_m.rx_done      = bus.rx_done;
  assign bus_m.tx_busy      = 1'b0;
  assign bus_m.output_valid = 1'b0;
  assign bus_m.fir_data_out = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_seen  = 0;
  logic [IN_W-1:0] exp_rx[$];
  logic [IN_W-1:0] exp_rx_m[$];
  logic [7:0]      exp_tx[$];
  logic            tmo_allowed = 1'b0;

  // UART transmitter model: busy for a few cycles after each tx_start
  int   busy_cnt  = 0;
  logic hold_busy = 1'b0;
  always @(posedge clk) begin
    if (bus.tx_start) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = hold_busy | (busy_cnt != 0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUTs present an output
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.input_valid) begin
        if (exp_rx.size() == 0) check("rx_unexpected_valid", bus.input_valid, 1'b0);
        else check("fir_data_in", bus.fir_data_in, exp_rx.pop_front());
      end
      if (bus_m.input_valid) begin
        if (exp_rx_m.size() == 0) check("rx_m_unexpected_valid", bus_m.input_valid, 1'b0);
        else check("fir_data_in_msb", bus_m.fir_data_in, exp_rx_m.pop_front());
      end
      if (bus.tx_start) begin
        tx_seen++;
        check("tx_busy_at_start", bus.tx_busy, 1'b0);
        if (exp_tx.size() == 0) check("tx_unexpected_start", bus.tx_start, 1'b0);
        else check("tx_data", bus.tx_data, exp_tx.pop_front());
      end
      if (bus.rx_timeout) check("rx_timeout_allowed", tmo_allowed, 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic push_result(input logic [OUT_W-1:0] w);
    bus.fir_data_out = w;
    bus.output_valid = 1'b1;
    @(posedge clk); #1;
    bus.output_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [OUT_W-1:0] w);
    logic [39:0] p;
    p = 40'(w);
    for (int i = 0; i < 5; i++) exp_tx.push_back(p[8*i +: 8]);
  endtask

  task automatic wait_tx_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_tx.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, exp_tx.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start"}, bus.tx_start, 1'b0);
    check({tag, "_tx_data"}, bus.tx_data, 8'h00);
    check({tag, "_input_valid"}, bus.input_valid, 1'b0);
    check({tag, "_fir_data_in"}, bus.fir_data_in, 16'h0000);
    check({tag, "_rx_timeout"}, bus.rx_timeout, 1'b0);
    check({tag, "_overflow"}, bus.overflow, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    logic [OUT_W-1:0] w;
    bus.rx_data      = 8'h00;
    bus.rx_done      = 1'b0;
    bus.output_valid = 1'b0;
    bus.fir_data_out = '0;
    rst = 1'b1;
    idle(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // LSB-first and MSB-first packing, 1-cycle latency, single pulse, hold
    exp_rx.push_back(16'hE291);
    exp_rx_m.push_back(16'h91E2);
    rx_byte(8'h91);
    check("input_valid_early", bus.input_valid, 1'b0);
    rx_byte(8'hE2);
    check("input_valid_latency", bus.input_valid, 1'b1);
    check("input_valid_latency_msb", bus_m.input_valid, 1'b1);
    idle(1);
    check("input_valid_one_cycle", bus.input_valid, 1'b0);
    check("fir_data_in_hold", bus.fir_data_in, 16'hE291);
    exp_rx.push_back(16'h3412);
    exp_rx_m.push_back(16'h1234);
    rx_byte(8'h12);
    idle(5);
    rx_byte(8'h34);
    idle(2);
    check("rx_queue_empty_1", exp_rx.size() + exp_rx_m.size(), 0);

    // Single result serialised LSB first
    exp_tx.push_back(8'h78);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h2A);
    push_result(38'h2A_1234_5678);
    wait_tx_drain("tx_drain_single", 500);
    idle(20);
    check("tx_data_hold", bus.tx_data, 8'h2A);
    check("overflow_clear", bus.overflow, 1'b0);

    // Overflow: transmitter held busy, six results, one in TX + four in FIFO survive
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = 38'h15_C0DE_0000 + 38'(i * 257);
      if (i < 5) expect_word(w);
      push_result(w);
      idle(1);
      if (i == 4) check("overflow_before_drop", bus.overflow, 1'b0);
    end
    check("overflow_set", bus.overflow, 1'b1);
    hold_busy = 1'b0;
    wait_tx_drain("tx_drain_overflow", 3000);
    idle(30);
    check("overflow_sticky", bus.overflow, 1'b1);

    // RX timeout after 100 idle cycles, then a clean sample
    tmo_allowed = 1'b1;
    rx_byte(8'h55);
    k = 0;
    while (!bus.rx_timeout && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("rx_timeout_cycles", k, 100);
    idle(1);
    check("rx_timeout_one_cycle", bus.rx_timeout, 1'b0);
    tmo_allowed = 1'b0;
    exp_rx.push_back(16'h0201);
    exp_rx_m.push_back(16'h0102);
    rx_byte(8'h01);
    rx_byte(8'h02);
    check("input_valid_after_timeout", bus.input_valid, 1'b1);
    // Byte arriving on the terminal timeout cycle is accepted, no timeout
    exp_rx.push_back(16'h2010);
    exp_rx_m.push_back(16'h1020);
    rx_byte(8'h10);
    idle(99);
    rx_byte(8'h20);
    check("input_valid_edge_timeout", bus.input_valid, 1'b1);
    idle(2);
    check("rx_queue_empty_2", exp_rx.size() + exp_rx_m.size(), 0);

    // Reset after two of five bytes: nothing more sent, FIFO flushed, partial lost
    base = tx_seen;
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'hBE);
    push_result(38'h3F_DEAD_BEEF);
    push_result(38'h11_2233_4455);
    k = 0;
    while (tx_seen < base + 2 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("tx_two_bytes_before_reset", tx_seen - base, 2);
    rx_byte(8'h77);
    rst = 1'b1;
    idle(2);
    check_outputs_zero("midreset");
    rst = 1'b0;
    idle(100);
    check("tx_after_reset", tx_seen - base, 2);
    exp_rx.push_back(16'h3CA5);
    exp_rx_m.push_back(16'hA53C);
    rx_byte(8'hA5);
    rx_byte(8'h3C);
    check("input_valid_after_reset", bus.input_valid, 1'b1);
    idle(3);
    check("rx_queue_empty_3", exp_rx.size() + exp_rx_m.size(), 0);
    check("tx_queue_empty_end", exp_tx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
